// File: rtl/branch_cmp_arbiter_pkg.sv
// Shared RV32I branch types for the comparator arbiter slice.
// Holds the funct3 encoding, the data word type and the illegal-funct3 helper.
package branch_cmp_arbiter_pkg;

    localparam int NUM_BR_REQ_MAX = 8;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_funct3_t;

    // funct3 010/011 have no branch meaning; everything else is a real branch.
    function automatic logic is_legal_branch(input logic [2:0] f3);
        logic legal;
        case (f3)
            3'b010, 3'b011: legal = 1'b0;
            default:        legal = 1'b1;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/branch_cmp_arbiter_if.sv
// Request/response bundle between NUM_REQ branch requesters and the shared comparator.
// The master side is the requesters; the slave side is the arbiter.
interface branch_cmp_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*3-1:0]     req_cmpop;
    logic [NUM_REQ*32-1:0]    req_a;
    logic [NUM_REQ*32-1:0]    req_b;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [NUM_REQ-1:0]       resp_br_en;
    logic [NUM_REQ-1:0]       resp_illegal;
    logic [NUM_REQ*TAG_W-1:0] resp_tag;

    modport master (
        output flush, req_valid, req_cmpop, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_br_en, resp_illegal, resp_tag
    );

    modport slave (
        input  flush, req_valid, req_cmpop, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_br_en, resp_illegal, resp_tag
    );
endinterface

// File: rtl/branch_cmp_arbiter_cmp.sv
// Branch comparator: evaluates one RV32I branch condition on two operands.
// Undefined funct3 values resolve to "not taken".
module cmp
    import branch_cmp_arbiter_pkg::*;
(
    input  logic [2:0] cmpop_i,
    input  rv32i_word  a_i,
    input  rv32i_word  b_i,
    output logic       br_en_o
);

    // Branch condition select.
    always_comb begin
        case (cmpop_i)
            BR_BEQ:  br_en_o = (a_i == b_i);
            BR_BNE:  br_en_o = (a_i != b_i);
            BR_BLT:  br_en_o = ($signed(a_i) <  $signed(b_i));
            BR_BGE:  br_en_o = ($signed(a_i) >= $signed(b_i));
            BR_BLTU: br_en_o = (a_i <  b_i);
            BR_BGEU: br_en_o = (a_i >= b_i);
            default: br_en_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cmp_arbiter_rr.sv
// Round-robin arbiter: scans requests starting at ptr_i, wrapping modulo N,
// and grants the first one found.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             any_gnt_o
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W:0]   wrap_s;
    logic [PTR_W-1:0] idx_s;
    logic             take_s;

    // ptr_i < N and k < N, so a single conditional subtract performs the modulo.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        sum_s     = '0;
        wrap_s    = '0;
        idx_s     = '0;
        take_s    = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s        = {1'b0, ptr_i} + (PTR_W+1)'(k);
            wrap_s       = (sum_s >= (PTR_W+1)'(N)) ? sum_s - (PTR_W+1)'(N) : sum_s;
            idx_s        = wrap_s[PTR_W-1:0];
            take_s       = !any_gnt_o && req_i[idx_s];
            gnt_o[idx_s] = take_s;
            gnt_idx_o    = take_s ? idx_s : gnt_idx_o;
            any_gnt_o    = any_gnt_o | take_s;
        end
    end

endmodule

// File: rtl/branch_cmp_arbiter.sv
// Shares one branch comparator among NUM_REQ requesters with round-robin grant
// and a registered one-entry response slot per requester.
module branch_cmp_arbiter
    import branch_cmp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_cmp_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [2:0]         op_s  [NUM_REQ];
    rv32i_word          a_s   [NUM_REQ];
    rv32i_word          b_s   [NUM_REQ];
    logic [TAG_W-1:0]   tag_s [NUM_REQ];

    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [PTR_W-1:0]   gnt_idx_s;
    logic               any_gnt_s;

    logic [2:0]         sel_op_s;
    rv32i_word          sel_a_s;
    rv32i_word          sel_b_s;
    logic               br_en_s;
    logic               illegal_s;

    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]       resp_valid_q;
    logic [NUM_REQ-1:0]       resp_br_en_q;
    logic [NUM_REQ-1:0]       resp_illegal_q;
    logic [NUM_REQ*TAG_W-1:0] resp_tag_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_s[i]  = bus.req_cmpop[i*3 +: 3];
        assign a_s[i]   = bus.req_a[i*32 +: 32];
        assign b_s[i]   = bus.req_b[i*32 +: 32];
        assign tag_s[i] = bus.req_tag[i*TAG_W +: TAG_W];
    end

    // A slot being drained this cycle frees its requester for a new grant.
    assign elig_s = bus.req_valid & ~(resp_valid_q & ~bus.resp_ready) & {NUM_REQ{~bus.flush}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i     (elig_s),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .any_gnt_o (any_gnt_s)
    );

    // Operand mux into the shared comparator; idle cycles present a quiet beq 0,0.
    always_comb begin
        if (any_gnt_s) begin
            sel_op_s = op_s[gnt_idx_s];
            sel_a_s  = a_s[gnt_idx_s];
            sel_b_s  = b_s[gnt_idx_s];
        end else begin
            sel_op_s = BR_BEQ;
            sel_a_s  = 32'h0000_0000;
            sel_b_s  = 32'h0000_0000;
        end
    end

    cmp u_cmp (
        .cmpop_i (sel_op_s),
        .a_i     (sel_a_s),
        .b_i     (sel_b_s),
        .br_en_o (br_en_s)
    );

    assign illegal_s = !is_legal_branch(sel_op_s);

    // Pointer moves just past the winner; no grant keeps it in place.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt_s) begin
            if (gnt_idx_s == PTR_W'(NUM_REQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_s + PTR_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Response slots and round-robin pointer; flush empties slots but keeps data and pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            resp_valid_q   <= '0;
            resp_br_en_q   <= '0;
            resp_illegal_q <= '0;
            resp_tag_q     <= '0;
        end else if (bus.flush) begin
            resp_valid_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_s[i]) begin
                    resp_valid_q[i]                <= 1'b1;
                    resp_br_en_q[i]                <= br_en_s;
                    resp_illegal_q[i]              <= illegal_s;
                    resp_tag_q[i*TAG_W +: TAG_W]   <= tag_s[i];
                end else if (bus.resp_ready[i]) begin
                    resp_valid_q[i]                <= 1'b0;
                end else begin
                    resp_valid_q[i]                <= resp_valid_q[i];
                end
            end
        end
    end

    assign bus.req_ready    = gnt_s;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_br_en   = resp_br_en_q;
    assign bus.resp_illegal = resp_illegal_q;
    assign bus.resp_tag     = resp_tag_q;

endmodule

// File: doc/branch_cmp_arbiter.md
Name: branch_cmp_arbiter

Overview:
- Shares one branch comparator (the existing `cmp` block) between NUM_REQ requesters, e.g. the pipeline EX-stage branch unit and the decode-stage early-resolve path.
- Grants at most one request per cycle using round-robin arbitration.
- Registers each comparison result into a per-requester 1-entry response slot.
- Each requester has its own valid/ready handshake on both the request and the response side.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TAG_W, 4, width of the opaque tag echoed from request to response.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; discards held responses.
- req_valid  in  NUM_REQ  request i is valid.
- req_ready  out  NUM_REQ  request i is accepted this cycle.
- req_cmpop  in  NUM_REQ*3  branch_funct3_t per requester.
- req_a  in  NUM_REQ*32  rs1 operand per requester.
- req_b  in  NUM_REQ*32  rs2/immediate operand per requester.
- req_tag  in  NUM_REQ*TAG_W  tag per requester.
- resp_valid  out  NUM_REQ  response slot i is full.
- resp_ready  in  NUM_REQ  requester i consumes its response.
- resp_br_en  out  NUM_REQ  comparison result.
- resp_illegal  out  NUM_REQ  cmpop was not a legal branch funct3.
- resp_tag  out  NUM_REQ*TAG_W  echoed tag.

Behaviour:
- Reset (async, rst_n=0):
  - resp_valid, resp_br_en, resp_illegal, resp_tag all 0.
  - rr_ptr = 0.
  - Takes effect immediately, including mid-transfer; an in-flight grant is lost.
- Eligibility:
  - elig[i] = req_valid[i] && (!resp_valid[i] || resp_ready[i]) && !flush.
  - A requester whose slot is being drained in the same cycle may be granted.
- Arbitration (combinational, same cycle as the request):
  - Scan i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first eligible requester is granted.
  - req_ready is one-hot or zero: req_ready[g] = 1 only for the granted g.
- Comparator path (combinational):
  - Granted operands and cmpop are muxed into `cmp`.
  - Ungranted cycles drive cmpop = beq with zero operands; the result is ignored.
- Latency: grant at edge t means, after edge t, resp_valid[g]=1, resp_br_en = cmp result, resp_tag = req_tag[g].
- Pointer update: on a grant, rr_ptr <= (g+1) mod NUM_REQ. No grant leaves rr_ptr unchanged.
- Slot drain: resp_valid[i] && resp_ready[i] with no new grant to i clears resp_valid[i] at the edge. Drain plus grant in the same cycle leaves the slot full with the new data.
- Illegal cmpop (funct3 010 or 011):
  - br_en = 0 (the comparator's default).
  - resp_illegal = 1.
  - The request is still granted and responded to.
- Flush:
  - In the flush cycle, req_ready = 0 for all requesters and there is no grant.
  - At the edge, all resp_valid clear.
  - rr_ptr is unchanged.
  - resp_ready during flush is don't-care.
- Holding: held responses stay stable until consumed. A full slot with resp_ready=0 blocks only that requester; others proceed.
- Throughput: 1 comparison per cycle aggregate. With N requesters continuously eligible, each requester is granted every N cycles (starvation-free).

Decomposition:
- Shared package rv32i_types: existing branch_funct3_t and rv32i_word. Add NUM_BR_REQ_MAX = 8.
- Sub-modules:
  - rr_arbiter (parameterised: req vector, pointer in → one-hot grant, grant index, any_grant).
  - Existing cmp, instantiated once.
- Response slots and rr_ptr register live in the top module.

Test Plan:
1. Reset released; req_valid=01, cmpop=beq, a=b=32'h5, tag=3 → req_ready=01 same cycle; next cycle resp_valid=01, br_en[0]=1, resp_tag[0]=3.
2. Both requesters valid every cycle, resp_ready=11; req0 blt a=32'hFFFFFFFF b=1, req1 bltu same operands → grants alternate 0,1,0,1 starting with 0; resp_br_en[0]=1, resp_br_en[1]=0.
3. Backpressure: resp_valid[1]=1 and resp_ready[1]=0, both requesting → req_ready[1]=0 every cycle, req0 granted every cycle. Raise resp_ready[1] → req1 granted that same cycle and slot holds new data next cycle.
4. Flush asserted while resp_valid=11 and both requesting → req_ready=00 that cycle; next cycle resp_valid=00 and rr_ptr unchanged.
5. Illegal cmpop 3'b010 on req0 → next cycle resp_valid[0]=1, br_en[0]=0, resp_illegal[0]=1.
6. rst_n pulsed low asynchronously mid-cycle with slots full → outputs go to 0 immediately; after release, first grant goes to requester 0.
